// File: rtl/cu_control_cluster_arbiter_pkg.sv
// Shared types and constants for the CU control cluster arbiter.
// Status bit positions and perf counter width live here.
package cu_control_cluster_arbiter_pkg;

  localparam int CU_ID_MAX_W = 8;
  typedef logic [CU_ID_MAX_W-1:0] cu_cluster_id_t;

  localparam int CU_STAT_BAD_ID  = 0;
  localparam int CU_STAT_BLOCKED = 1;
  localparam int CU_STAT_GNT_LSB = 32;
  localparam int CU_STAT_RSP_LSB = 48;
  localparam int CU_CNT_W        = 16;

  function automatic logic [CU_CNT_W-1:0] cu_sat_inc(
    input logic [CU_CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/cu_control_cluster_arbiter_if.sv
// Shared read-command / response channel between the arbiter
// (master side) and the downstream memory port (slave side).
interface cu_control_cluster_arbiter_if #(
  parameter int CMD_PAYLOAD_W = 128,
  parameter int RSP_PAYLOAD_W = 64,
  parameter int ID_W          = 2
);
  logic                     cmd_valid_out;
  logic [CMD_PAYLOAD_W-1:0] cmd_payload_out;
  logic [ID_W-1:0]          cmd_id_out;
  logic                     cmd_alfull_in;
  logic                     rsp_valid_in;
  logic [RSP_PAYLOAD_W-1:0] rsp_payload_in;
  logic [ID_W-1:0]          rsp_id_in;

  modport master (
    output cmd_valid_out,
    output cmd_payload_out,
    output cmd_id_out,
    input  cmd_alfull_in,
    input  rsp_valid_in,
    input  rsp_payload_in,
    input  rsp_id_in
  );

  modport slave (
    input  cmd_valid_out,
    input  cmd_payload_out,
    input  cmd_id_out,
    output cmd_alfull_in,
    output rsp_valid_in,
    output rsp_payload_in,
    output rsp_id_in
  );
endinterface

// File: rtl/cu_control_cluster_arbiter_delay.sv
// Valid+data shift register; data only moves with its valid so
// idle cycles leave the last payload on the output.
module cu_delay_line #(
  parameter int STAGES = 1,
  parameter int W      = 8
) (
  input  logic         clock,
  input  logic         rstn,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [STAGES-1:0] v;
  logic [W-1:0]      d [STAGES];

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      v <= '0;
      for (int s = 0; s < STAGES; s++)
        d[s] <= '0;
    end else begin
      v[0] <= in_valid;
      if (in_valid)
        d[0] <= in_data;
      for (int s = 1; s < STAGES; s++) begin
        v[s] <= v[s-1];
        if (v[s-1])
          d[s] <= d[s-1];
      end
    end
  end

  assign out_valid = v[STAGES-1];
  assign out_data  = d[STAGES-1];

endmodule

// File: rtl/cu_control_cluster_arbiter_rr.sv
// Round-robin picker: first requester at or after ptr, wrapping.
// Pure combinational; the caller owns the pointer register.
module cu_rr_arbiter #(
  parameter int NUM_CLUSTERS = 4,
  parameter int ID_W         = $clog2(NUM_CLUSTERS)
) (
  input  logic [NUM_CLUSTERS-1:0] req,
  input  logic [ID_W-1:0]         ptr,
  output logic [NUM_CLUSTERS-1:0] gnt,
  output logic [ID_W-1:0]         win
);

  logic            found;
  logic [ID_W:0]   sum;
  logic [ID_W-1:0] idx;

  always_comb begin
    gnt   = '0;
    win   = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < NUM_CLUSTERS; i++) begin
      sum = {1'b0, ptr} + (ID_W+1)'(i);
      if (sum >= (ID_W+1)'(NUM_CLUSTERS))
        sum = sum - (ID_W+1)'(NUM_CLUSTERS);
      idx = sum[ID_W-1:0];
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        win      = idx;
      end
    end
  end

endmodule

// File: rtl/cu_control_cluster_arbiter.sv
// Multi-cluster CU control boundary: RR command arbiter, response router.
// Optional grant/response counters: define CU_CONTROL_ARB_PERF_CNT_EN.
module cu_control_cluster_arbiter
  import cu_control_cluster_arbiter_pkg::*;
#(
  parameter int NUM_CLUSTERS  = 4,
  parameter int CMD_PAYLOAD_W = 128,
  parameter int RSP_PAYLOAD_W = 64,
  parameter int IN_STAGES     = 1,
  parameter int OUT_STAGES    = 1
) (
  input  logic                  clock,
  input  logic                  rstn_in,
  input  logic                  enabled_in,
  input  logic [NUM_CLUSTERS-1:0] cl_cmd_valid_in,
  input  logic [NUM_CLUSTERS*CMD_PAYLOAD_W-1:0] cl_cmd_payload_in,
  output logic [NUM_CLUSTERS-1:0] cl_cmd_grant_out,
  cu_control_cluster_arbiter_if.master chan,
  output logic [NUM_CLUSTERS-1:0] cl_rsp_valid_out,
  output logic [RSP_PAYLOAD_W-1:0] cl_rsp_payload_out,
  input  logic [NUM_CLUSTERS-1:0] cl_done_in,
  output logic                  cu_done_out,
  output logic [63:0]           cu_status_out
);

  localparam int ID_W = $clog2(NUM_CLUSTERS);
  localparam int NC   = NUM_CLUSTERS;
  localparam int CW   = CMD_PAYLOAD_W;
  localparam int RW   = RSP_PAYLOAD_W;

  // Assert follows rstn_in at once; release waits for a clock edge.
  logic rstn_internal;
  always_ff @(posedge clock or negedge rstn_in) begin
    if (!rstn_in) rstn_internal <= 1'b0;
    else          rstn_internal <= 1'b1;
  end

  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] win_id;
  logic [NC-1:0]   arb_gnt;
  logic            grant_en;
  logic [CW-1:0]   cmd_sel;
  logic [ID_W+CW-1:0] cmd_q;

  cu_rr_arbiter #(
    .NUM_CLUSTERS(NC),
    .ID_W        (ID_W)
  ) u_arb (
    .req(cl_cmd_valid_in),
    .ptr(rr_ptr),
    .gnt(arb_gnt),
    .win(win_id)
  );

  assign grant_en = rstn_internal & enabled_in
                  & ~chan.cmd_alfull_in & (|cl_cmd_valid_in);
  assign cl_cmd_grant_out = grant_en ? arb_gnt : '0;

  always_ff @(posedge clock or negedge rstn_internal) begin
    if (!rstn_internal)
      rr_ptr <= '0;
    else if (grant_en)
      rr_ptr <= (win_id == ID_W'(NC-1)) ? '0 : win_id + 1'b1;
  end

  always_comb begin
    cmd_sel = '0;
    for (int i = 0; i < NC; i++)
      if (arb_gnt[i])
        cmd_sel = cmd_sel | cl_cmd_payload_in[i*CW +: CW];
  end

  cu_delay_line #(
    .STAGES(OUT_STAGES),
    .W     (ID_W + CW)
  ) u_cmd_dl (
    .clock    (clock),
    .rstn     (rstn_internal),
    .in_valid (grant_en),
    .in_data  ({win_id, cmd_sel}),
    .out_valid(chan.cmd_valid_out),
    .out_data (cmd_q)
  );

  assign chan.cmd_id_out      = cmd_q[ID_W+CW-1:CW];
  assign chan.cmd_payload_out = cmd_q[CW-1:0];

  cu_cluster_id_t     rsp_id_ext;
  logic               rsp_bad;
  logic               rsp_ok;
  logic               rsp_v;
  logic [ID_W-1:0]    rsp_id_q;
  logic [ID_W+RW-1:0] rsp_q;

  assign rsp_id_ext = cu_cluster_id_t'(chan.rsp_id_in);
  assign rsp_bad = chan.rsp_valid_in
                 & (rsp_id_ext >= cu_cluster_id_t'(NC));
  assign rsp_ok  = chan.rsp_valid_in & ~rsp_bad;

  cu_delay_line #(
    .STAGES(IN_STAGES),
    .W     (ID_W + RW)
  ) u_rsp_dl (
    .clock    (clock),
    .rstn     (rstn_internal),
    .in_valid (rsp_ok),
    .in_data  ({chan.rsp_id_in, chan.rsp_payload_in}),
    .out_valid(rsp_v),
    .out_data (rsp_q)
  );

  assign rsp_id_q           = rsp_q[ID_W+RW-1:RW];
  assign cl_rsp_payload_out = rsp_q[RW-1:0];

  always_comb begin
    cl_rsp_valid_out = '0;
    for (int i = 0; i < NC; i++)
      cl_rsp_valid_out[i] = rsp_v & (rsp_id_q == ID_W'(i));
  end

  logic bad_id;
  logic blocked;

  always_ff @(posedge clock or negedge rstn_internal) begin
    if (!rstn_internal) begin
      bad_id      <= 1'b0;
      cu_done_out <= 1'b0;
    end else begin
      bad_id      <= bad_id | rsp_bad;
      cu_done_out <= cu_done_out | (&cl_done_in);
    end
  end

  assign blocked = rstn_internal & chan.cmd_alfull_in
                 & (|cl_cmd_valid_in);

`ifdef CU_CONTROL_ARB_PERF_CNT_EN
  logic [CU_CNT_W-1:0] gnt_cnt;
  logic [CU_CNT_W-1:0] rsp_cnt;

  always_ff @(posedge clock or negedge rstn_internal) begin
    if (!rstn_internal) begin
      gnt_cnt <= '0;
      rsp_cnt <= '0;
    end else begin
      if (grant_en) gnt_cnt <= cu_sat_inc(gnt_cnt);
      if (rsp_v)    rsp_cnt <= cu_sat_inc(rsp_cnt);
    end
  end
`endif

  always_comb begin
    cu_status_out = '0;
    cu_status_out[CU_STAT_BAD_ID]  = bad_id;
    cu_status_out[CU_STAT_BLOCKED] = blocked;
`ifdef CU_CONTROL_ARB_PERF_CNT_EN
    cu_status_out[CU_STAT_GNT_LSB +: CU_CNT_W] = gnt_cnt;
    cu_status_out[CU_STAT_RSP_LSB +: CU_CNT_W] = rsp_cnt;
`endif
  end

endmodule

// File: tb/tb_cu_control_cluster_arbiter.sv
// Bench for cu_control_cluster_arbiter: vector table, directed corners,
// random traffic against a queue-based reference model.
module tb_cu_control_cluster_arbiter;

  localparam int N    = 5;
  localparam int CW   = 32;
  localparam int RW   = 64;
  localparam int INS  = 2;
  localparam int OUTS = 3;
  localparam int ID_W = 3;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          rstn_in;
  logic          en;
  logic [N-1:0]  req;
  logic [N*CW-1:0] pay;
  logic [N-1:0]  grant;
  logic [N-1:0]  rsp_v;
  logic [RW-1:0] rsp_pay;
  logic [N-1:0]  done_in;
  logic          done_out;
  logic [63:0]   status;

  cu_control_cluster_arbiter_if #(
    .CMD_PAYLOAD_W(CW),
    .RSP_PAYLOAD_W(RW),
    .ID_W         (ID_W)
  ) bus ();

  cu_control_cluster_arbiter #(
    .NUM_CLUSTERS (N),
    .CMD_PAYLOAD_W(CW),
    .RSP_PAYLOAD_W(RW),
    .IN_STAGES    (INS),
    .OUT_STAGES   (OUTS)
  ) dut (
    .clock             (clock),
    .rstn_in           (rstn_in),
    .enabled_in        (en),
    .cl_cmd_valid_in   (req),
    .cl_cmd_payload_in (pay),
    .cl_cmd_grant_out  (grant),
    .chan              (bus.master),
    .cl_rsp_valid_out  (rsp_v),
    .cl_rsp_payload_out(rsp_pay),
    .cl_done_in        (done_in),
    .cu_done_out       (done_out),
    .cu_status_out     (status)
  );

  int checks = 0;
  int fails  = 0;

  function automatic void chk(string name, logic [63:0] got,
                              logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endfunction

  typedef struct {
    bit            v;
    int            id;
    logic [CW-1:0] pay;
  } cmd_rec_t;

  typedef struct {
    bit            v;
    int            id;
    logic [RW-1:0] pay;
  } rsp_rec_t;

  cmd_rec_t cmd_q[$];
  rsp_rec_t rsp_q[$];
  int       m_ptr;
  bit       m_done;
  bit       m_bad;
  int       m_gcnt;
  int       m_rcnt;
  logic [N-1:0] m_grant;

  logic [N-1:0]  s_grant;
  logic [N-1:0]  s_rsp_v;
  logic [RW-1:0] s_rsp_pay;
  logic          s_done;
  logic [63:0]   s_status;

  task automatic model_reset();
    cmd_rec_t c;
    rsp_rec_t r;
    c = '{v: 1'b0, id: 0, pay: '0};
    r = '{v: 1'b0, id: 0, pay: '0};
    m_ptr = 0; m_done = 0; m_bad = 0;
    m_gcnt = 0; m_rcnt = 0;
    cmd_q.delete();
    rsp_q.delete();
    repeat (OUTS) cmd_q.push_back(c);
    repeat (INS) rsp_q.push_back(r);
  endtask

  // One clock: check DUT at negedge against the model, then advance it.
  task automatic cycle();
    int w;
    int idx;
    cmd_rec_t ec;
    rsp_rec_t er;
    cmd_rec_t nc;
    rsp_rec_t nr;
    logic [N-1:0] ev;
    logic [63:0] es;
    int rid;
    @(negedge clock);
    w = -1;
    if (en && !bus.cmd_alfull_in && (|req))
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (w < 0 && req[idx]) w = idx;
      end
    m_grant = '0;
    if (w >= 0) m_grant[w] = 1'b1;
    chk("grant", 64'(grant), 64'(m_grant));
    ec = cmd_q[0];
    chk("cmd_valid", 64'(bus.cmd_valid_out), 64'(ec.v));
    if (ec.v) begin
      chk("cmd_id", 64'(bus.cmd_id_out), 64'(ec.id));
      chk("cmd_payload", 64'(bus.cmd_payload_out), 64'(ec.pay));
    end
    er = rsp_q[0];
    ev = er.v ? (N'(1) << er.id) : '0;
    chk("rsp_valid", 64'(rsp_v), 64'(ev));
    if (er.v) chk("rsp_payload", rsp_pay, er.pay);
    chk("done", 64'(done_out), 64'(m_done));
    es = '0;
    es[0] = m_bad;
    es[1] = (|req) && bus.cmd_alfull_in;
`ifdef CU_CONTROL_ARB_PERF_CNT_EN
    es[47:32] = 16'(m_gcnt);
    es[63:48] = 16'(m_rcnt);
`endif
    chk("status", status, es);
    s_grant = grant; s_rsp_v = rsp_v; s_rsp_pay = rsp_pay;
    s_done = done_out; s_status = status;
    if (w >= 0) begin
      m_ptr = (w + 1) % N;
      if (m_gcnt < 65535) m_gcnt++;
    end
    nc.v = (w >= 0);
    nc.id = w;
    nc.pay = (w >= 0) ? pay[w*CW +: CW] : '0;
    cmd_q.push_back(nc);
    void'(cmd_q.pop_front());
    rid = int'(bus.rsp_id_in);
    nr.v = bus.rsp_valid_in && (rid < N);
    nr.id = rid;
    nr.pay = bus.rsp_payload_in;
    rsp_q.push_back(nr);
    void'(rsp_q.pop_front());
    if (er.v && m_rcnt < 65535) m_rcnt++;
    if (bus.rsp_valid_in && rid >= N) m_bad = 1;
    if (&done_in) m_done = 1;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    rstn_in = 1'b0;
    #2;
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_cmd_valid", 64'(bus.cmd_valid_out), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_v), 64'd0);
    chk("rst_done", 64'(done_out), 64'd0);
    chk("rst_status", status, 64'd0);
    req = '0;
    bus.rsp_valid_in = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    rstn_in = 1'b1;
    @(posedge clock);
    #1;
    model_reset();
  endtask

  typedef struct packed {
    logic [N-1:0] req;
    logic         al;
    logic         en;
    logic [N-1:0] done;
    logic [N-1:0] exp_gnt;
    logic         exp_done;
  } vec_t;

  vec_t tbl [12];

  initial begin
    tbl[0]  = '{5'b01111, 1'b0, 1'b1, 5'b00000, 5'b00001, 1'b0};
    tbl[1]  = '{5'b01111, 1'b0, 1'b1, 5'b00000, 5'b00010, 1'b0};
    tbl[2]  = '{5'b01111, 1'b0, 1'b1, 5'b00000, 5'b00100, 1'b0};
    tbl[3]  = '{5'b01111, 1'b0, 1'b1, 5'b00000, 5'b01000, 1'b0};
    tbl[4]  = '{5'b01111, 1'b0, 1'b1, 5'b00000, 5'b00001, 1'b0};
    tbl[5]  = '{5'b10000, 1'b0, 1'b0, 5'b00000, 5'b00000, 1'b0};
    tbl[6]  = '{5'b10001, 1'b0, 1'b1, 5'b00000, 5'b10000, 1'b0};
    tbl[7]  = '{5'b10001, 1'b0, 1'b1, 5'b00000, 5'b00001, 1'b0};
    tbl[8]  = '{5'b00000, 1'b0, 1'b1, 5'b01111, 5'b00000, 1'b0};
    tbl[9]  = '{5'b00000, 1'b0, 1'b1, 5'b11111, 5'b00000, 1'b0};
    tbl[10] = '{5'b00000, 1'b0, 1'b1, 5'b00000, 5'b00000, 1'b1};
    tbl[11] = '{5'b00000, 1'b0, 1'b1, 5'b00000, 5'b00000, 1'b1};

    rstn_in = 1'b0;
    en = 1'b1;
    req = '1;
    done_in = '0;
    for (int i = 0; i < N; i++)
      pay[i*CW +: CW] = 32'hA000_0000 | 32'(i);
    bus.cmd_alfull_in  = 1'b0;
    bus.rsp_valid_in   = 1'b0;
    bus.rsp_id_in      = '0;
    bus.rsp_payload_in = '0;
    @(posedge clock);
    #1;
    req = '1;
    do_reset();

    for (int t = 0; t < 12; t++) begin
      req = tbl[t].req;
      bus.cmd_alfull_in = tbl[t].al;
      en = tbl[t].en;
      done_in = tbl[t].done;
      cycle();
      chk($sformatf("tbl%0d_grant", t), 64'(s_grant),
          64'(tbl[t].exp_gnt));
      chk($sformatf("tbl%0d_done", t), 64'(s_done),
          64'(tbl[t].exp_done));
    end

    req = 5'b00100;
    bus.cmd_alfull_in = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cycle();
      chk("bp_grant", 64'(s_grant), 64'd0);
      chk("bp_status1", 64'(s_status[1]), 64'd1);
    end
    bus.cmd_alfull_in = 1'b0;
    cycle();
    chk("bp_release", 64'(s_grant), 64'(5'b00100));
    req = '0;

    bus.rsp_valid_in = 1'b1;
    bus.rsp_id_in = 3'd3;
    bus.rsp_payload_in = 64'hDEAD;
    cycle();
    bus.rsp_valid_in = 1'b0;
    bus.rsp_payload_in = '0;
    cycle();
    chk("route_early", 64'(s_rsp_v), 64'd0);
    cycle();
    chk("route_valid", 64'(s_rsp_v), 64'(5'b01000));
    chk("route_payload", s_rsp_pay, 64'hDEAD);

    bus.rsp_valid_in = 1'b1;
    bus.rsp_id_in = 3'd7;
    cycle();
    bus.rsp_valid_in = 1'b0;
    cycle();
    cycle();
    chk("badid_valid", 64'(s_rsp_v), 64'd0);
    chk("badid_status0", 64'(s_status[0]), 64'd1);

    req = '1;
    repeat (OUTS) cycle();
    rstn_in = 1'b0;
    #2;
    chk("midrst_cmd_valid", 64'(bus.cmd_valid_out), 64'd0);
    do_reset();
    for (int c = 0; c < OUTS + 1; c++) begin
      cycle();
      chk("postrst_idle", 64'(s_grant), 64'd0);
    end
    req = '1;
    cycle();
    chk("postrst_ptr0", 64'(s_grant), 64'd1);
    req = '0;
    repeat (OUTS) cycle();

    for (int c = 0; c < 400; c++) begin
      en = ($urandom_range(0, 9) != 0);
      bus.cmd_alfull_in = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++)
        if (!req[i] && $urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          pay[i*CW +: CW] = $urandom;
        end
      bus.rsp_valid_in = 1'($urandom_range(0, 1));
      bus.rsp_id_in = 3'($urandom_range(0, 7));
      bus.rsp_payload_in = {$urandom, $urandom};
      done_in = ($urandom_range(0, 49) == 0) ? '1 : N'($urandom);
      cycle();
      req = req & ~m_grant;
    end
    bus.rsp_valid_in = 1'b0;

`ifdef CU_CONTROL_ARB_PERF_CNT_EN
    req = '1;
    en = 1'b1;
    bus.cmd_alfull_in = 1'b0;
    repeat (70000) cycle();
    chk("gnt_cnt_sat", 64'(s_status[47:32]), 64'hFFFF);
`else
    cycle();
    chk("upper_status_zero", s_status[63:2], 62'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
